// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared state encodings and opcode constants for the fetch sequencer
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_RUN  = 3'd1,
    ST_HALT = 3'd2,
    ST_STEP = 3'd3
  } state_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0000_000D;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - decoder/fetch-unit side signals of the fetch sequencer
interface fetch_sequencer_if #(
  parameter int CNT_W = 32
);

  logic [31:0]      instruction;
  logic             branch;
  logic             zero;
  logic             run_req;
  logic             halt_req;
  logic             step_req;
  logic             pc_en;
  logic             pc_init;
  logic             npc_sel;
  logic             halted;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    output instruction, branch, zero, run_req, halt_req, step_req,
    input  pc_en, pc_init, npc_sel, halted, state, retired
  );

  modport slave (
    input  instruction, branch, zero, run_req, halt_req, step_req,
    output pc_en, pc_init, npc_sel, halted, state, retired
  );

endinterface

// File: rtl/fetch_sequencer_edge_detect.sv
// rtl/fetch_sequencer_edge_detect.sv - single-bit rising-edge detector
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_pulse
);

  logic r_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d <= 1'b0;
    end else begin
      r_d <= i_d;
    end
  end

  assign o_pulse = i_d & ~r_d;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch control FSM: reset-vector hold, run/halt/step, retired count
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          RESET_HOLD_CYCLES = 2,
  parameter bit          AUTO_RUN          = 1'b1,
  parameter logic [31:0] HALT_WORD         = HALT_WORD_DEFAULT,
  parameter int          CNT_W             = 32
) (
  input  logic              clk,
  input  logic              start_up,
  fetch_sequencer_if.slave  bus
);

  localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  state_t             r_state;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [CNT_W-1:0]   r_retired;
  logic               w_is_halt;
  logic               w_step_pulse;
  logic               w_pc_en;

  edge_detect u_step_edge (
    .clk     (clk),
    .rst     (start_up),
    .i_d     (bus.step_req),
    .o_pulse (w_step_pulse)
  );

  assign w_is_halt = (bus.instruction == HALT_WORD);

  // PC update is gated in the same cycle so a halt never lets one extra fetch slip through
  always_comb begin
    w_pc_en = 1'b0;
    case (r_state)
      ST_RUN:  w_pc_en = ~w_is_halt & ~bus.halt_req;
      ST_STEP: w_pc_en = ~w_is_halt;
      default: w_pc_en = 1'b0;
    endcase
  end

  assign bus.pc_en   = w_pc_en;
  assign bus.pc_init = (r_state == ST_INIT);
  assign bus.halted  = (r_state == ST_HALT);
  assign bus.npc_sel = w_pc_en & bus.branch & bus.zero;
  assign bus.state   = r_state;
  assign bus.retired = r_retired;

  always_ff @(posedge clk or posedge start_up) begin
    if (start_up) begin
      r_state    <= ST_INIT;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_hold_cnt <= '0;
            r_state    <= AUTO_RUN ? ST_RUN : ST_HALT;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (w_is_halt || bus.halt_req) begin
            r_state <= ST_HALT;
          end
        end
        ST_HALT: begin
          if (bus.run_req && !bus.halt_req) begin
            r_state <= ST_RUN;
          end else if (w_step_pulse) begin
            r_state <= ST_STEP;
          end
        end
        ST_STEP: r_state <= ST_HALT;
        default: r_state <= ST_HALT;
      endcase
    end
  end

  // Saturating so a long free run never wraps back to a small count
  always_ff @(posedge clk or posedge start_up) begin
    if (start_up) begin
      r_retired <= '0;
    end else if (w_pc_en && (r_retired != {CNT_W{1'b1}})) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic clk;
  logic start_up;
  logic start_up_s;
  int   n_checks;
  int   n_pass;

  fetch_sequencer_if #(.CNT_W(32)) bus ();
  fetch_sequencer_if #(.CNT_W(3))  bus_s ();

  fetch_sequencer #(
    .RESET_HOLD_CYCLES (2),
    .AUTO_RUN          (1'b1),
    .HALT_WORD         (32'h0000_000D),
    .CNT_W             (32)
  ) u_dut (
    .clk      (clk),
    .start_up (start_up),
    .bus      (bus.slave)
  );

  // Narrow counter and single-cycle hold, used for the saturation case
  fetch_sequencer #(
    .RESET_HOLD_CYCLES (1),
    .AUTO_RUN          (1'b1),
    .HALT_WORD         (32'h0000_000D),
    .CNT_W             (3)
  ) u_dut_sat (
    .clk      (clk),
    .start_up (start_up_s),
    .bus      (bus_s.slave)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    start_up   = 1'b1;
    start_up_s = 1'b1;
    bus.instruction = 32'h0000_0013;
    bus.branch   = 1'b0;
    bus.zero     = 1'b0;
    bus.run_req  = 1'b0;
    bus.halt_req = 1'b0;
    bus.step_req = 1'b0;
    bus_s.instruction = 32'h0000_0013;
    bus_s.branch   = 1'b0;
    bus_s.zero     = 1'b0;
    bus_s.run_req  = 1'b0;
    bus_s.halt_req = 1'b0;
    bus_s.step_req = 1'b0;

    #1;
    check("rst_state",   64'(bus.state),   64'd0);
    check("rst_pc_init", 64'(bus.pc_init), 64'd1);
    check("rst_pc_en",   64'(bus.pc_en),   64'd0);
    check("rst_npc_sel", 64'(bus.npc_sel), 64'd0);
    check("rst_halted",  64'(bus.halted),  64'd0);
    check("rst_retired", 64'(bus.retired), 64'd0);

    // Release at t=5, a falling edge; first rising edge at t=10
    #4;
    start_up = 1'b0;
    tick(1);
    check("hold1_pc_init", 64'(bus.pc_init), 64'd1);
    check("hold1_pc_en",   64'(bus.pc_en),   64'd0);
    check("hold1_state",   64'(bus.state),   64'd0);
    tick(1);
    check("run_state",   64'(bus.state),   64'd1);
    check("run_pc_en",   64'(bus.pc_en),   64'd1);
    check("run_pc_init", 64'(bus.pc_init), 64'd0);
    check("run_retired0", 64'(bus.retired), 64'd0);
    tick(10);
    check("run_retired10", 64'(bus.retired), 64'd10);

    bus.branch = 1'b1;
    bus.zero   = 1'b1;
    #1;
    check("br_taken_npc", 64'(bus.npc_sel), 64'd1);
    bus.zero = 1'b0;
    #1;
    check("br_not_taken_npc", 64'(bus.npc_sel), 64'd0);
    bus.zero     = 1'b1;
    bus.halt_req = 1'b1;
    #1;
    check("br_halt_npc",   64'(bus.npc_sel), 64'd0);
    check("br_halt_pc_en", 64'(bus.pc_en),   64'd0);
    bus.halt_req = 1'b0;
    bus.branch   = 1'b0;
    bus.zero     = 1'b0;

    // Asynchronous abort between edges while running
    #1;
    start_up = 1'b1;
    #1;
    check("abort_state",   64'(bus.state),   64'd0);
    check("abort_retired", 64'(bus.retired), 64'd0);
    check("abort_pc_init", 64'(bus.pc_init), 64'd1);
    check("abort_pc_en",   64'(bus.pc_en),   64'd0);
    @(negedge clk);
    start_up = 1'b0;
    tick(2);
    check("rerun_state", 64'(bus.state), 64'd1);
    tick(7);
    check("pre_halt_retired", 64'(bus.retired), 64'd7);

    bus.instruction = 32'h0000_000D;
    #1;
    check("hword_pc_en", 64'(bus.pc_en), 64'd0);
    tick(1);
    check("hword_state",   64'(bus.state),   64'd2);
    check("hword_halted",  64'(bus.halted),  64'd1);
    check("hword_retired", 64'(bus.retired), 64'd7);
    bus.instruction = 32'h0000_0013;
    #1;
    check("halt_pc_en", 64'(bus.pc_en), 64'd0);

    // step_req held high for three cycles yields exactly one step
    bus.step_req = 1'b1;
    tick(1);
    check("step_state",  64'(bus.state),  64'd3);
    check("step_pc_en",  64'(bus.pc_en),  64'd1);
    check("step_halted", 64'(bus.halted), 64'd0);
    tick(1);
    check("step_back_state", 64'(bus.state),   64'd2);
    check("step_back_pc_en", 64'(bus.pc_en),   64'd0);
    check("step_retired",    64'(bus.retired), 64'd8);
    tick(1);
    check("step_held_state",   64'(bus.state),   64'd2);
    check("step_held_retired", 64'(bus.retired), 64'd8);
    bus.step_req = 1'b0;
    tick(1);
    bus.step_req = 1'b1;
    tick(1);
    check("step2_state", 64'(bus.state), 64'd3);
    tick(1);
    check("step2_retired", 64'(bus.retired), 64'd9);
    bus.step_req = 1'b0;
    tick(1);

    bus.instruction = 32'h0000_000D;
    bus.step_req    = 1'b1;
    tick(1);
    check("step_hword_state", 64'(bus.state), 64'd3);
    check("step_hword_pc_en", 64'(bus.pc_en), 64'd0);
    tick(1);
    check("step_hword_back",    64'(bus.state),   64'd2);
    check("step_hword_retired", 64'(bus.retired), 64'd9);
    bus.instruction = 32'h0000_0013;
    bus.step_req    = 1'b0;
    tick(1);

    bus.run_req  = 1'b1;
    bus.halt_req = 1'b1;
    tick(1);
    check("run_blocked_state", 64'(bus.state), 64'd2);
    bus.halt_req = 1'b0;
    bus.step_req = 1'b1;
    tick(1);
    check("run_beats_step_state", 64'(bus.state), 64'd1);
    bus.run_req  = 1'b0;
    bus.step_req = 1'b0;
    #1;
    check("resume_pc_en", 64'(bus.pc_en), 64'd1);
    bus.halt_req = 1'b1;
    tick(1);
    check("halt_req_state",   64'(bus.state),   64'd2);
    check("halt_req_retired", 64'(bus.retired), 64'd9);
    bus.halt_req = 1'b0;

    start_up_s = 1'b1;
    #1;
    check("sat_rst_retired", 64'(bus_s.retired), 64'd0);
    @(negedge clk);
    start_up_s = 1'b0;
    tick(1);
    check("sat_run_state", 64'(bus_s.state), 64'd1);
    tick(5);
    check("sat_retired5", 64'(bus_s.retired), 64'd5);
    tick(5);
    check("sat_retired10", 64'(bus_s.retired), 64'd7);
    tick(3);
    check("sat_retired_hold", 64'(bus_s.retired), 64'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control FSM that sequences the instruction fetch unit (PC register, next-PC mux, instruction memory).
- Drives PC write enable, reset-vector hold and branch select (nPC_sel).
- Supports free run, halt on request or on the HALT_WORD opcode, and debug single-step.
- Counts retired instructions.
- Sits between the main control decoder/ALU flags and the fetch unit.

Parameters:
- RESET_HOLD_CYCLES, 2: cycles the PC is held at the reset vector after start_up deasserts; legal values are 1 or more.
- AUTO_RUN, 1: 1 enters RUN after the hold; 0 enters HALT after the hold.
- HALT_WORD, 32'h0000_000D: instruction encoding that stops fetch.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk, input, 1: system clock; rising edge.
- start_up, input, 1: asynchronous, active-high reset.
- instruction, input, 32: current instruction word from the fetch unit.
- branch, input, 1: current instruction is a conditional branch (from the decoder).
- zero, input, 1: ALU zero flag for the current instruction.
- run_req, input, 1: level; leave HALT and free-run.
- halt_req, input, 1: level; stop fetch.
- step_req, input, 1: a rising edge executes one instruction while halted.
- pc_en, output, 1: PC register write enable.
- pc_init, output, 1: forces the PC to the reset vector.
- npc_sel, output, 1: selects the branch target in the next-PC mux.
- halted, output, 1: high in HALT.
- state, output, 3: encoded FSM state, for debug.
- retired, output, CNT_W: count of instructions retired.

Behaviour:
- Reset (start_up=1, asynchronous):
  - state=INIT(0), hold counter=0, retired=0, step edge register=0.
  - Outputs: pc_init=1, pc_en=0, npc_sel=0, halted=0.
- State encoding: INIT=0, RUN=1, HALT=2, STEP=3. Codes 4–7 are illegal and return to HALT on the next edge.
- Internal signals:
  - is_halt = (instruction == HALT_WORD).
  - step_pulse = step_req & ~step_req_d, where step_req_d is step_req registered.
- INIT:
  - pc_init=1, pc_en=0.
  - Hold counter increments each cycle.
  - When the counter reaches RESET_HOLD_CYCLES-1, go to RUN if AUTO_RUN=1, else HALT.
  - pc_init drops in the first cycle of the new state.
- RUN:
  - pc_en = ~is_halt & ~halt_req. This is combinational, same cycle.
  - If is_halt or halt_req: go to HALT. The PC does not advance and the instruction is not retired. is_halt and halt_req have the same effect; is_halt has priority only for the purpose of HALT entry.
  - Otherwise stay in RUN.
- HALT:
  - halted=1, pc_en=0.
  - run_req=1 and halt_req=0: go to RUN.
  - Otherwise step_pulse=1: go to STEP.
  - run_req beats step_pulse when both are present.
  - halt_req=1 blocks run_req but not step.
- STEP (exactly one cycle):
  - pc_en = ~is_halt.
  - Always returns to HALT.
  - A step onto HALT_WORD advances nothing.
- npc_sel = pc_en & branch & zero. It is 0 whenever pc_en=0.
- retired:
  - Increments by 1 on every clock edge where pc_en=1.
  - Saturates at 2^CNT_W-1; no wrap.
- start_up asserted in any state aborts immediately:
  - Outputs go to their reset values in the same cycle, with no wait for an edge.
  - retired clears.
- Latency:
  - Control outputs are combinational from state and inputs; there is no added pipeline.
  - A halt_req assertion suppresses the PC update on the same edge.

Decomposition:
- Shared package fetch_pkg:
  - State encodings: INIT, RUN, HALT, STEP.
  - HALT_WORD default value.
  - Shared with the decoder and testbench.
- One natural sub-module, edge_detect: a 1-bit rising-edge detector for step_req, with asynchronous start_up reset.
- The counter and FSM stay inline.

Test Plan:
1. Reset and hold:
   - Stimulus: start_up=1 for 5 ns, then release; RESET_HOLD_CYCLES=2, AUTO_RUN=1.
   - Required: pc_init=1 and pc_en=0 for 2 edges. Then state=RUN and pc_en=1. After 10 further edges, retired=10.
2. Branch select:
   - Stimulus: in RUN, branch=1 and zero=1 → npc_sel=1.
   - Stimulus: branch=1 and zero=0 → npc_sel=0.
   - Stimulus: halt_req=1 with branch=1 and zero=1 → npc_sel=0 and pc_en=0.
3. Halt opcode:
   - Stimulus: drive instruction=32'h0000_000D in RUN with retired=7.
   - Required: pc_en=0 that cycle, next state=HALT, halted=1, retired stays 7.
4. Single step:
   - Stimulus: in HALT, one step_req pulse held for 3 cycles.
   - Required: exactly one cycle with pc_en=1, then back to HALT; retired +1. A second rising edge gives another +1.
5. Priority:
   - Stimulus: in HALT, run_req=1 and a step_req edge in the same cycle → RUN.
   - Stimulus: in HALT, run_req=1 with halt_req=1 → stays HALT.
6. Asynchronous reset mid-run and saturation:
   - Stimulus: assert start_up between clock edges while in RUN.
   - Required: state=0, retired=0, pc_init=1 immediately.
   - Stimulus: with CNT_W=3, run 10 cycles.
   - Required: retired=7 and holds.
